pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
// - Interlock/forwarding scheduler for the 5-stage LA32R core; sits beside the ID stage.
// - Keeps a 3-slot scoreboard (EXE/MEM/WB) of in-flight register writes, advanced by the
//   inter-stage handshakes.
// - Drives the ID stall and the per-operand forwarding selects. Replaces the ad hoc
//   priority muxes in ID.
// PARAMETERS
// - RF_AW   5   register address width
// - CNT_W   16  width of the stall performance counter (used only with HAZ_PERF_CNT_EN)
// PORTS
// - clk           in   1      clock
// - reset         in   1      asynchronous, active-high
// - ds_valid      in   1      ID holds a valid instruction
// - ds_raddr1     in   RF_AW  ID source 1 (rj)
// - ds_raddr2     in   RF_AW  ID source 2 (rk or rd)
// - ds_src1_used  in   1      source 1 actually read
// - ds_src2_used  in   1      source 2 actually read
// - ds_rf_we      in   1      ID instruction writes the RF
// - ds_rf_waddr   in   RF_AW  ID destination
// - ds_is_load    in   1      ID instruction is ld.w
// - ds_to_es      in   1      ID->EXE transfer this cycle (ds_ready_go & es_allow_in & ds_valid)
// - es_to_ms      in   1      EXE->MEM transfer this cycle
// - ms_to_ws      in   1      MEM->WB transfer this cycle
// - stall         out  1      ID must hold (feeds ds_ready_go = !stall)
// - fwd_sel1      out  2      source 1 select: 00 RF, 01 EXE, 10 MEM, 11 WB
// - fwd_sel2      out  2      source 2 select, same encoding
// - stall_cnt     out  CNT_W  stall-cycle count (HAZ_PERF_CNT_EN only)
// BEHAVIOUR
// - Slot fields: {v, waddr, ld}. v = valid & rf_we & (waddr != 0). r0 is never tracked.
// - Slot update at posedge clk. Priority is as listed; all three slots update in the same
//   edge from pre-edge values.
//   - E <= ds_to_es ? {ds_valid & ds_rf_we & (ds_rf_waddr != 0), ds_rf_waddr, ds_is_load}
//         : es_to_ms ? empty : E
//   - M <= es_to_ms ? E : ms_to_ws ? empty : M
//   - W <= ms_to_ws ? M : empty   (WB is single-cycle; an unrefreshed W retires)
// - Simultaneous ds_to_es and es_to_ms: E takes the new entry and M takes the old E.
//   No entry is lost or duplicated.
// - Forwarding (combinational, per source s):
//   - Youngest match wins: E hit -> 01, else M hit -> 10, else W hit -> 11, else 00.
//   - hit = slot.v & (slot.waddr == raddr_s) & src_s_used.
//   - raddr == 0 or src_s_used = 0 -> 00.
// - Load-use stall (combinational):
//   - stall = ds_valid & (E.v & E.ld & (E.waddr matches a used source)).
//   - A load in MEM or WB does not stall; its data is forwarded.
// - While stall = 1, ds_to_es is 0 by construction, so E drains to MEM and stall drops
//   the next cycle. A single load-use costs exactly 1 bubble.
// - E is empty after a stall cycle. The upstream pipeline deasserts ds_to_es, so no
//   bubble is inserted as a valid slot.
// - Reset (async): all slots empty; stall = 0, fwd_sel* = 00, stall_cnt = 0.
//   A mid-operation reset discards every tracked entry immediately.
// - Outputs depend only on slot state plus ID inputs. No cycles of latency are added
//   to the ID decision.
// CONFIGURATION
// - HAZ_PERF_CNT_EN defined: stall_cnt increments on every cycle with stall = 1 and
//   saturates at 2^CNT_W - 1.
// - HAZ_PERF_CNT_EN undefined: stall_cnt is tied to 0 and its register is not built.
// TESTING
// - add r5 in EXE, ID add r6,r5,r7 (src1_used) -> stall = 0, fwd_sel1 = 01, fwd_sel2 = 00.
// - ld.w r4 in EXE, ID beq r4,r9 -> stall = 1 for exactly 1 cycle; next cycle
//   fwd_sel1 = 10, stall = 0.
// - r8 written by both EXE and MEM entries, ID reads r8 -> fwd_sel = 01 (youngest).
// - ID reads r0 while EXE writes r0 -> fwd_sel = 00, stall = 0, E.v = 0 after transfer.
// - Back-to-back transfers for 3 cycles then idle -> E, M, W empty by cycle 3; reset
//   asserted mid-stream -> all selects 00 on the same cycle.
// - HAZ_PERF_CNT_EN: 3 load-use stalls -> stall_cnt = 3; forced saturation with
//   CNT_W = 2 -> holds at 3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage <-> hazard controller bundle: ID operands/destination, stage handshakes,
// and the stall / forwarding-select / perf-counter results.
interface pipeline_hazard_ctrl_if #(
    parameter int RF_AW = 5,
    parameter int CNT_W = 16
);
    logic             ds_valid;
    logic [RF_AW-1:0] ds_raddr1;
    logic [RF_AW-1:0] ds_raddr2;
    logic             ds_src1_used;
    logic             ds_src2_used;
    logic             ds_rf_we;
    logic [RF_AW-1:0] ds_rf_waddr;
    logic             ds_is_load;
    logic             ds_to_es;
    logic             es_to_ms;
    logic             ms_to_ws;
    logic             stall;
    logic [1:0]       fwd_sel1;
    logic [1:0]       fwd_sel2;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ds_valid, ds_raddr1, ds_raddr2, ds_src1_used, ds_src2_used,
               ds_rf_we, ds_rf_waddr, ds_is_load, ds_to_es, es_to_ms, ms_to_ws,
        input  stall, fwd_sel1, fwd_sel2, stall_cnt
    );

    modport slave (
        input  ds_valid, ds_raddr1, ds_raddr2, ds_src1_used, ds_src2_used,
               ds_rf_we, ds_rf_waddr, ds_is_load, ds_to_es, es_to_ms, ms_to_ws,
        output stall, fwd_sel1, fwd_sel2, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use interlock and forwarding-select scheduler with an EXE/MEM/WB write scoreboard.
// Optional stall-cycle performance counter enabled by defining HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int RF_AW = 5,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic             v;
        logic [RF_AW-1:0] waddr;
        logic             ld;
    } slot_t;

    slot_t e_q, e_d, m_q, m_d, w_q, w_d;
    slot_t ds_entry;

    // r0 writes are never tracked, so a read of r0 can never hit a slot.
    assign ds_entry = '{v:     bus.ds_valid & bus.ds_rf_we & (bus.ds_rf_waddr != '0),
                        waddr: bus.ds_rf_waddr,
                        ld:    bus.ds_is_load};

    always_comb begin
        e_d = e_q;
        m_d = m_q;
        w_d = '0;
        if (bus.ds_to_es)      e_d = ds_entry;
        else if (bus.es_to_ms) e_d = '0;
        if (bus.es_to_ms)      m_d = e_q;
        else if (bus.ms_to_ws) m_d = '0;
        if (bus.ms_to_ws)      w_d = m_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    logic [RF_AW-1:0] raddr [2];
    logic             used  [2];
    logic [1:0]       sel   [2];
    logic [1:0]       ld_hit;

    assign raddr[0] = bus.ds_raddr1;
    assign raddr[1] = bus.ds_raddr2;
    assign used[0]  = bus.ds_src1_used;
    assign used[1]  = bus.ds_src2_used;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic hit_e, hit_m, hit_w;
            assign hit_e = used[gi] & e_q.v & (e_q.waddr == raddr[gi]);
            assign hit_m = used[gi] & m_q.v & (m_q.waddr == raddr[gi]);
            assign hit_w = used[gi] & w_q.v & (w_q.waddr == raddr[gi]);
            // Youngest producer wins.
            assign sel[gi]    = hit_e ? 2'b01 : hit_m ? 2'b10 : hit_w ? 2'b11 : 2'b00;
            assign ld_hit[gi] = hit_e & e_q.ld;
        end
    endgenerate

    assign bus.fwd_sel1 = sel[0];
    assign bus.fwd_sel2 = sel[1];
    // Only a load still in EXE has no data yet; MEM/WB loads are forwarded.
    assign bus.stall    = bus.ds_valid & (|ld_hit);

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bus.stall_cnt = cnt_q;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
`endif
endmodule
